instr_cache: RTL

- Direct-mapped, read-only instruction cache that serves fetches from the PC path.
- Receives the PC value produced by pcAdder/jumpbranchAdder through mux32. Returns the 32-bit instruction and stalls the CPU with BUSYWAIT on a miss.
- On a miss it acts as the initiator toward instruction memory, fetching whole 128-bit blocks.

---
 rtl/instr_cache_pkg.sv | 34 +++
 rtl/instr_cache_if.sv | 15 +
 rtl/instr_cache_fsm.sv | 67 ++++++
 rtl/instr_cache.sv | 75 +++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache: address fields, FSM states
// and memory-bus widths, also intended for reuse by the data cache.
package instr_cache_pkg;

  localparam int NUM_LINES       = 8;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int ADDR_BITS       = 10;
  localparam int TAG_W           = 3;
  localparam int IDX_W           = 3;
  localparam int OFF_W           = 2;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int MEM_ADDR_W      = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  // Pick one 32-bit word out of a block; word0 sits in the low bits.
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFF_W-1:0]   off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = blk[31:0];
      2'd1:    w = blk[63:32];
      2'd2:    w = blk[95:64];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Block-read bus between a cache (master) and instruction memory (slave).
interface instr_cache_if;
  import instr_cache_pkg::*;

  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0]    mem_readdata;
  logic                  mem_busywait;

  modport master (output mem_read, output mem_address,
                  input  mem_readdata, input mem_busywait);
  modport slave  (input  mem_read, input mem_address,
                  output mem_readdata, output mem_busywait);

endinterface

// File: rtl/instr_cache_fsm.sv
// Miss-handling controller: tracks IDLE/MEM_READ/UPDATE, drives the memory
// handshake and tells the datapath when to capture and when to fill a line.
module instr_cache_fsm
  import instr_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic [MEM_ADDR_W-1:0] block_addr,
  input  logic                  mem_busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic                  busywait,
  output logic                  capture,
  output logic                  fill,
  output logic [MEM_ADDR_W-1:0] fill_addr
);

  state_t                state;
  state_t                next_state;
  logic [MEM_ADDR_W-1:0] addr_q;

  assign fill_addr = addr_q;

  // State register; reset abandons any in-flight fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Latch the block address on the miss so a wandering PC cannot redirect the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     addr_q <= '0;
    else if (state == IDLE && !hit) addr_q <= block_addr;
  end

  // Next-state and handshake outputs; busywait is forced low while reset is held.
  always_comb begin
    next_state  = state;
    mem_read    = 1'b0;
    mem_address = '0;
    busywait    = 1'b1;
    capture     = 1'b0;
    fill        = 1'b0;
    case (state)
      IDLE: begin
        busywait = !hit;
        if (!hit) next_state = MEM_READ;
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        if (!mem_busywait) begin
          capture    = 1'b1;
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        fill       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) busywait = 1'b0;
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: 8 lines of 128-bit blocks,
// combinational hit/word select, block fills through instr_cache_fsm.
module instr_cache
  import instr_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  output logic [WORD_W-1:0]  instruction,
  output logic               busywait,
  instr_cache_if.master      mem_bus
);

  logic [TAG_W-1:0]      pc_tag;
  logic [IDX_W-1:0]      pc_idx;
  logic [OFF_W-1:0]      pc_off;
  logic                  unused_pc;

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]    data_q [NUM_LINES];
  logic [BLOCK_W-1:0]    block_buf;

  logic                  hit;
  logic                  capture;
  logic                  fill;
  logic [MEM_ADDR_W-1:0] fill_addr;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;

  assign pc_tag    = pc[9:7];
  assign pc_idx    = pc[6:4];
  assign pc_off    = pc[3:2];
  assign unused_pc = ^{pc[31:10], pc[1:0]};

  assign fill_idx  = fill_addr[IDX_W-1:0];
  assign fill_tag  = fill_addr[MEM_ADDR_W-1:IDX_W];

  assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign instruction = select_word(data_q[pc_idx], pc_off);

  instr_cache_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .hit          (hit),
    .block_addr   (pc[9:4]),
    .mem_busywait (mem_bus.mem_busywait),
    .mem_read     (mem_bus.mem_read),
    .mem_address  (mem_bus.mem_address),
    .busywait     (busywait),
    .capture      (capture),
    .fill         (fill),
    .fill_addr    (fill_addr)
  );

  // Valid bits are the only storage that reset must clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid_q <= '0;
    else if (fill) valid_q[fill_idx] <= 1'b1;
  end

  // Tag and data are only meaningful once valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= block_buf;
    end
  end

  // Hold the returned block from the last MEM_READ edge until UPDATE writes it.
  always_ff @(posedge clk) begin
    if (capture) block_buf <= mem_bus.mem_readdata;
  end

endmodule
